// File: rtl/alu_pkg.sv
// alu_pkg: constants shared between the ALU and the multiply sequencer.
//   - 5-bit ALU function selects (bit 4 set means 32-bit width)
//   - ALU flag bit indices inside the {Z,C,N,O} flag vector
//   - multiply sequencer state encoding
package alu_pkg;

    localparam logic [4:0] PASS_A = 5'b10000;
    localparam logic [4:0] AND32  = 5'b10001;
    localparam logic [4:0] OR32   = 5'b10010;
    localparam logic [4:0] XOR32  = 5'b10011;
    localparam logic [4:0] ADD32  = 5'b10100;
    localparam logic [4:0] SUB32  = 5'b10101;
    localparam logic [4:0] LSL32  = 5'b11011;
    localparam logic [4:0] LSR32  = 5'b11100;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StShift,
        StFlag,
        StDone
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// alu: small 32-bit ALU with a combinational result and registered flags.
// Ports:
//   clk_i, rst_ni : clock, active-low asynchronous reset (flags only)
//   a_i, b_i      : operands
//   fun_sel_i     : function select (alu_pkg constants)
//   wf_i          : when high, flags {Z,C,N,O} of this cycle's result are registered
//   out_o         : combinational result
//   flags_o       : registered flags {Z,C,N,O}
module alu
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  fun_sel_i,
    input  logic        wf_i,
    output logic [31:0] out_o,
    output logic [3:0]  flags_o
);

    logic [31:0] res;
    logic        carry;
    logic        ovf;
    logic [3:0]  flags_q;

    always_comb begin
        res   = a_i;
        carry = 1'b0;
        ovf   = 1'b0;
        case (fun_sel_i)
            PASS_A: res = a_i;
            AND32:  res = a_i & b_i;
            OR32:   res = a_i | b_i;
            XOR32:  res = a_i ^ b_i;
            ADD32: begin
                {carry, res} = {1'b0, a_i} + {1'b0, b_i};
                ovf = (a_i[31] == b_i[31]) && (res[31] != a_i[31]);
            end
            SUB32: begin
                {carry, res} = {1'b0, a_i} - {1'b0, b_i};
                ovf = (a_i[31] != b_i[31]) && (res[31] != a_i[31]);
            end
            LSL32: {carry, res} = {a_i, 1'b0};
            LSR32: {res, carry} = {1'b0, a_i};
            default: res = a_i;
        endcase
    end

    assign out_o = res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= 4'b0000;
        end else if (wf_i) begin
            flags_q[FLAG_Z] <= (res == 32'h0);
            flags_q[FLAG_C] <= carry;
            flags_q[FLAG_N] <= res[31];
            flags_q[FLAG_O] <= ovf;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16x16 unsigned shift-and-add multiplier that borrows an
// external ALU for every add, shift and the final zero-flag evaluation.
// Ports:
//   Clock, Reset         : clock, synchronous active-high reset
//   Start, OpA, OpB      : multiply request and unsigned operands (sampled in IDLE)
//   Busy, Done           : not-idle indicator, one-cycle completion pulse
//   Product, ProductZero : registered result and its zero flag (held until next DONE)
//   AluA, AluB, AluFunSel, AluWF : drive to the shared ALU
//   AluOut, AluFlags     : combinational result / registered flags from the ALU
module alu_mul_sequencer
    import alu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] OpA,
    input  logic [15:0] OpB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic        ProductZero,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags
);

    seq_state_e  state_q;
    logic [31:0] m_q;
    logic [15:0] q_q;
    logic [31:0] p_q;
    logic [3:0]  cnt_q;
    logic [31:0] product_q;
    logic        product_zero_q;

    // Only Z is consumed; the other flag bits belong to other ALU users.
    logic [2:0]  flags_unused;
    assign flags_unused = AluFlags[2:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= StIdle;
            m_q            <= 32'h0;
            q_q            <= 16'h0;
            p_q            <= 32'h0;
            cnt_q          <= 4'h0;
            product_q      <= 32'h0;
            product_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        m_q     <= {16'h0, OpA};
                        q_q     <= OpB;
                        p_q     <= 32'h0;
                        cnt_q   <= 4'h0;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    p_q     <= AluOut;
                    state_q <= StShift;
                end
                StShift: begin
                    // Bit shifted out of M is dropped; 16 fixed iterations, no early exit.
                    m_q     <= AluOut;
                    q_q     <= q_q >> 1;
                    cnt_q   <= cnt_q + 4'd1;
                    state_q <= (cnt_q == 4'd15) ? StFlag : StAdd;
                end
                StFlag: begin
                    state_q <= StDone;
                end
                StDone: begin
                    // Flags were written by the ALU at the end of FLAG, so Z is valid here.
                    product_q      <= p_q;
                    product_zero_q <= AluFlags[FLAG_Z];
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        AluFunSel = PASS_A;
        AluA      = 32'h0;
        AluB      = 32'h0;
        AluWF     = 1'b0;
        unique case (state_q)
            StAdd: begin
                AluFunSel = ADD32;
                AluA      = p_q;
                AluB      = q_q[0] ? m_q : 32'h0;
            end
            StShift: begin
                AluFunSel = LSL32;
                AluA      = m_q;
            end
            StFlag: begin
                AluFunSel = PASS_A;
                AluA      = p_q;
                AluWF     = 1'b1;
            end
            default: begin
                AluFunSel = PASS_A;
            end
        endcase
    end

    assign Busy        = (state_q != StIdle);
    assign Done        = (state_q == StDone);
    assign Product     = product_q;
    assign ProductZero = product_zero_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic        Busy;
    logic        Done;
    logic [31:0] Product;
    logic        ProductZero;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    alu_mul_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .OpA         (OpA),
        .OpB         (OpB),
        .Busy        (Busy),
        .Done        (Done),
        .Product     (Product),
        .ProductZero (ProductZero),
        .AluA        (AluA),
        .AluB        (AluB),
        .AluFunSel   (AluFunSel),
        .AluWF       (AluWF),
        .AluOut      (AluOut),
        .AluFlags    (AluFlags)
    );

    alu u_alu (
        .clk_i     (Clock),
        .rst_ni    (~Reset),
        .a_i       (AluA),
        .b_i       (AluB),
        .fun_sel_i (AluFunSel),
        .wf_i      (AluWF),
        .out_o     (AluOut),
        .flags_o   (AluFlags)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one multiply (Start sampled at the next edge, "edge 0") and follow it
    // until Done or a 60-cycle budget. Cycle k is the period after k edges.
    // g1/g2: cycles during which Start is held high again (should be ignored).
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int g1, input int g2,
                           output int lat, output int wf_cyc, output int wf_cnt,
                           output int busy_low,
                           output logic [4:0] f1, output logic [31:0] a1, output logic [31:0] b1,
                           output logic [4:0] f2, output logic [31:0] a2, output logic [31:0] b2);
        lat = -1; wf_cyc = -1; wf_cnt = 0; busy_low = 0;
        f1 = '0; a1 = '0; b1 = '0; f2 = '0; a2 = '0; b2 = '0;
        OpA   = a;
        OpB   = b;
        Start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            Start = (k == g1) || (k == g2);
            OpA   = ~a;  // operands must have been latched at edge 0
            OpB   = ~b;
            if (k == 1) begin f1 = AluFunSel; a1 = AluA; b1 = AluB; end
            if (k == 2) begin f2 = AluFunSel; a2 = AluA; b2 = AluB; end
            if (AluWF) begin wf_cnt++; wf_cyc = k; end
            if (!Busy) busy_low++;
            if (Done) begin lat = k; break; end
        end
    endtask

    int lat, wf_cyc, wf_cnt, busy_low, extra_done;
    logic [4:0]  f1, f2;
    logic [31:0] a1, b1, a2, b2;

    initial begin
        vecs[0] = '{a: 16'd3,    b: 16'd5,    prod: 32'h0000000F, zero: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, prod: 32'hFFFE0001, zero: 1'b0};
        vecs[2] = '{a: 16'h0000, b: 16'h1234, prod: 32'h00000000, zero: 1'b1};
        vecs[3] = '{a: 16'h0001, b: 16'h0001, prod: 32'h00000001, zero: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h0002, prod: 32'h00010000, zero: 1'b0};
        vecs[5] = '{a: 16'h00FF, b: 16'h0100, prod: 32'h0000FF00, zero: 1'b0};
        vecs[6] = '{a: 16'h1234, b: 16'h0000, prod: 32'h00000000, zero: 1'b1};
        vecs[7] = '{a: 16'hABCD, b: 16'h0001, prod: 32'h0000ABCD, zero: 1'b0};
        vecs[8] = '{a: 16'd100,  b: 16'd200,  prod: 32'h00004E20, zero: 1'b0};

        Reset = 1'b1; Start = 1'b0; OpA = '0; OpB = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset_busy", {31'h0, Busy}, 32'h0);
        check("reset_done", {31'h0, Done}, 32'h0);
        check("reset_product", Product, 32'h0);
        check("reset_pzero", {31'h0, ProductZero}, 32'h0);
        check("reset_aluwf", {31'h0, AluWF}, 32'h0);
        check("idle_funsel", {27'h0, AluFunSel}, {27'h0, PASS_A});
        check("idle_alua", AluA, 32'h0);
        check("idle_alub", AluB, 32'h0);
        Reset = 1'b0;

        // Start low in IDLE: stays idle.
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("idle_hold_busy", {31'h0, Busy}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_mul(vecs[i].a, vecs[i].b, 0, 0, lat, wf_cyc, wf_cnt, busy_low,
                    f1, a1, b1, f2, a2, b2);
            check($sformatf("v%0d_latency", i), lat, 34);
            check($sformatf("v%0d_wf_count", i), wf_cnt, 1);
            check($sformatf("v%0d_wf_cycle", i), wf_cyc, 33);
            check($sformatf("v%0d_busy_gap", i), busy_low, 0);
            if (i == 0) begin
                check("v0_add_funsel", {27'h0, f1}, {27'h0, ADD32});
                check("v0_add_a", a1, 32'h0);
                check("v0_add_b", b1, 32'h3);
                check("v0_shift_funsel", {27'h0, f2}, {27'h0, LSL32});
                check("v0_shift_a", a2, 32'h3);
                check("v0_shift_b", b2, 32'h0);
            end
            @(posedge Clock);
            @(negedge Clock);
            check($sformatf("v%0d_product", i), Product, vecs[i].prod);
            check($sformatf("v%0d_pzero", i), {31'h0, ProductZero}, {31'h0, vecs[i].zero});
            check($sformatf("v%0d_idle_after", i), {31'h0, Busy}, 32'h0);
        end

        // Start pulsed at cycles 5 and 34 (the DONE cycle): both ignored.
        run_mul(16'd6, 16'd7, 5, 34, lat, wf_cyc, wf_cnt, busy_low, f1, a1, b1, f2, a2, b2);
        check("ign_latency", lat, 34);
        check("ign_wf_count", wf_cnt, 1);
        check("ign_busy_gap", busy_low, 0);
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        check("ign_busy_35", {31'h0, Busy}, 32'h0);
        check("ign_product", Product, 32'h0000002A);
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (Done || Busy) extra_done++;
        end
        check("ign_no_second_run", extra_done, 0);

        // Reset at cycle 10 of a multiply.
        OpA = 16'd7; OpB = 16'd9; Start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            Start = 1'b0;
        end
        check("rst_mid_busy_before", {31'h0, Busy}, 32'h1);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("rst_mid_busy", {31'h0, Busy}, 32'h0);
        check("rst_mid_product", Product, 32'h0);
        check("rst_mid_done", {31'h0, Done}, 32'h0);
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (Done) extra_done++;
        end
        check("rst_mid_no_done", extra_done, 0);
        run_mul(16'd7, 16'd9, 0, 0, lat, wf_cyc, wf_cnt, busy_low, f1, a1, b1, f2, a2, b2);
        check("rst_after_latency", lat, 34);
        @(posedge Clock);
        @(negedge Clock);
        check("rst_after_product", Product, 32'h0000003F);

        // Reset wins over Start in the same cycle.
        Reset = 1'b1; Start = 1'b1; OpA = 16'd2; OpB = 16'd2;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0; Start = 1'b0;
        check("rst_prio_busy", {31'h0, Busy}, 32'h0);
        check("rst_prio_product", Product, 32'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_prio_still_idle", {31'h0, Busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
